// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups.
// Groups are spread across STAGES register stages with valid/ready flow control.
module cla_pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             OV,
  output logic             Z
);

  localparam int NG  = WIDTH / 4;
  localparam int GPS = (NG + STAGES - 1) / STAGES;
  localparam int NR  = (STAGES > 1) ? STAGES - 1 : 1;

  // Returns {group generate, group propagate} for one 4-bit slice.
  function automatic logic [1:0] grp_pg(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] g;
    logic [3:0] p;
    g = a & b;
    p = a | b;
    return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p};
  endfunction

  // Returns {carry into bit 3, 4-bit sum}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    g    = a & b;
    p    = a | b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return {c[3], a ^ b ^ c};
  endfunction

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] vld_src;
  logic [STAGES-1:0] load;

  logic [WIDTH-1:0] a_q   [NR];
  logic [WIDTH-1:0] b_q   [NR];
  logic [WIDTH-1:0] sum_q [NR];
  logic             c_q   [NR];
  logic             cwm1_q[NR];

  // A stage loads when it is empty or its successor drains it this cycle.
  always_comb begin : flow
    logic ld;
    load = '0;
    ld   = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld      = ~vld[k] | ld;
      load[k] = ld;
    end
  end

  always_comb begin
    vld_src    = '0;
    vld_src[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      vld_src[k] = vld[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) vld[k] <= vld_src[k];
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = vld[STAGES-1];

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO = s * GPS;
    localparam int HI = (LO + GPS > NG) ? NG : LO + GPS;

    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] sum_n;
    logic             c_s;
    logic             cwm1_s;
    logic             c_n;
    logic             cwm1_n;

    if (s == 0) begin : g_src
      assign a_s    = A;
      assign b_s    = sub ? ~B : B;
      assign c_s    = sub ? 1'b1 : Ci;
      assign sum_s  = '0;
      assign cwm1_s = 1'b0;
    end else begin : g_src
      assign a_s    = a_q[s-1];
      assign b_s    = b_q[s-1];
      assign c_s    = c_q[s-1];
      assign sum_s  = sum_q[s-1];
      assign cwm1_s = cwm1_q[s-1];
    end

    // Second lookahead level: carry into each owned group is expanded from the
    // stage carry-in and the group P/G terms rather than rippled group to group.
    always_comb begin : lookahead
      logic       acc;
      logic       prod;
      logic       cin;
      logic [1:0] gp;
      logic [4:0] r;
      sum_n  = sum_s;
      cwm1_n = cwm1_s;
      acc    = 1'b0;
      prod   = 1'b1;
      cin    = 1'b0;
      gp     = '0;
      r      = '0;
      for (int k = 0; k < NG; k++) begin
        acc  = 1'b0;
        prod = 1'b1;
        for (int j = k - 1; j >= LO; j--) begin
          gp   = grp_pg(a_s[4*j +: 4], b_s[4*j +: 4]);
          acc  = acc | (gp[1] & prod);
          prod = prod & gp[0];
        end
        cin = acc | (prod & c_s);
        r   = cla4(a_s[4*k +: 4], b_s[4*k +: 4], cin);
        if (k >= LO && k < HI) begin
          sum_n[4*k +: 4] = r[3:0];
          if (k == NG - 1) cwm1_n = r[4];
        end
      end
      acc  = 1'b0;
      prod = 1'b1;
      for (int j = HI - 1; j >= LO; j--) begin
        gp   = grp_pg(a_s[4*j +: 4], b_s[4*j +: 4]);
        acc  = acc | (gp[1] & prod);
        prod = prod & gp[0];
      end
      c_n = acc | (prod & c_s);
    end

    if (s < STAGES - 1) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q[s]    <= '0;
          b_q[s]    <= '0;
          sum_q[s]  <= '0;
          c_q[s]    <= 1'b0;
          cwm1_q[s] <= 1'b0;
        end else if (load[s] && vld_src[s]) begin
          a_q[s]    <= a_s;
          b_q[s]    <= b_s;
          sum_q[s]  <= sum_n;
          c_q[s]    <= c_n;
          cwm1_q[s] <= cwm1_n;
        end
      end
    end else begin : g_out
      // Result flags are formed from the final sum and the two top carries.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          S  <= '0;
          Co <= 1'b0;
          OV <= 1'b0;
          Z  <= 1'b0;
        end else if (load[s] && vld_src[s]) begin
          S  <= sum_n;
          Co <= c_n;
          OV <= c_n ^ cwm1_n;
          Z  <= ~|sum_n;
        end
      end
    end
  end

endmodule
